// File: rtl/wb_arbiter.sv
// Write-back arbiter: two per-source FIFOs, round-robin issue of one (index, data) per cycle.
// Optional macro WB_ARB_FWD_EN enables empty-FIFO forwarding straight to the output register.
module wb_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned INDEX_W    = 6,
  parameter int unsigned DATA_W     = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               I_Stall,
  input  logic               I_Bypass_Full,
  input  logic               I_Valid_A,
  input  logic [INDEX_W-1:0] I_Index_A,
  input  logic [DATA_W-1:0]  I_Data_A,
  input  logic               I_Valid_B,
  input  logic [INDEX_W-1:0] I_Index_B,
  input  logic [DATA_W-1:0]  I_Data_B,
  output logic               O_Full_A,
  output logic               O_Full_B,
  output logic               O_WB_Valid,
  output logic [INDEX_W-1:0] O_WB_Index,
  output logic [DATA_W-1:0]  O_WB_Data,
  output logic               O_Overflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = INDEX_W + DATA_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [ENT_W-1:0]   r_mem_a [FIFO_DEPTH];
  logic [ENT_W-1:0]   r_mem_b [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wptr_a, r_rptr_a, r_wptr_b, r_rptr_b;
  logic [CNT_W-1:0]   r_cnt_a, r_cnt_b;
  logic [CNT_W-1:0]   w_cnt_a_d, w_cnt_b_d;
  logic               r_prio_b;
  logic               r_overflow;
  logic               r_wb_valid;
  logic [INDEX_W-1:0] r_wb_index;
  logic [DATA_W-1:0]  r_wb_data;

  logic w_en, w_ne_a, w_ne_b, w_req_a, w_req_b;
  logic w_gnt_a, w_gnt_b, w_pop_a, w_pop_b, w_fwd_a, w_fwd_b;
  logic w_push_a, w_push_b, w_wr_a, w_wr_b;

  assign O_Full_A   = (r_cnt_a == DEPTH_C);
  assign O_Full_B   = (r_cnt_b == DEPTH_C);
  assign O_WB_Valid = r_wb_valid;
  assign O_WB_Index = r_wb_index;
  assign O_WB_Data  = r_wb_data;
  assign O_Overflow = r_overflow;

  assign w_en   = ~I_Stall & ~I_Bypass_Full;
  assign w_ne_a = (r_cnt_a != '0);
  assign w_ne_b = (r_cnt_b != '0);

`ifdef WB_ARB_FWD_EN
  // An empty FIFO with an incoming result competes as if that result were its head.
  assign w_req_a = w_ne_a | I_Valid_A;
  assign w_req_b = w_ne_b | I_Valid_B;
`else
  assign w_req_a = w_ne_a;
  assign w_req_b = w_ne_b;
`endif

  // r_prio_b set means B was not granted last, so B wins a tie.
  assign w_gnt_a = w_en & w_req_a & (~w_req_b | ~r_prio_b);
  assign w_gnt_b = w_en & w_req_b & (~w_req_a |  r_prio_b);
  assign w_pop_a = w_gnt_a & w_ne_a;
  assign w_pop_b = w_gnt_b & w_ne_b;
  assign w_fwd_a = w_gnt_a & ~w_ne_a;
  assign w_fwd_b = w_gnt_b & ~w_ne_b;

  assign w_push_a = I_Valid_A & ~O_Full_A;
  assign w_push_b = I_Valid_B & ~O_Full_B;
  assign w_wr_a   = w_push_a & ~w_fwd_a;
  assign w_wr_b   = w_push_b & ~w_fwd_b;

  always_comb begin
    w_cnt_a_d = r_cnt_a;
    if (w_wr_a && !w_pop_a)      w_cnt_a_d = r_cnt_a + 1'b1;
    else if (!w_wr_a && w_pop_a) w_cnt_a_d = r_cnt_a - 1'b1;
    w_cnt_b_d = r_cnt_b;
    if (w_wr_b && !w_pop_b)      w_cnt_b_d = r_cnt_b + 1'b1;
    else if (!w_wr_b && w_pop_b) w_cnt_b_d = r_cnt_b - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (w_wr_a) r_mem_a[r_wptr_a] <= {I_Index_A, I_Data_A};
    if (w_wr_b) r_mem_b[r_wptr_b] <= {I_Index_B, I_Data_B};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr_a   <= '0;
      r_rptr_a   <= '0;
      r_cnt_a    <= '0;
      r_wptr_b   <= '0;
      r_rptr_b   <= '0;
      r_cnt_b    <= '0;
      r_prio_b   <= 1'b0;
      r_overflow <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_index <= '0;
      r_wb_data  <= '0;
    end else begin
      r_cnt_a <= w_cnt_a_d;
      r_cnt_b <= w_cnt_b_d;
      if (w_wr_a)  r_wptr_a <= r_wptr_a + 1'b1;
      if (w_wr_b)  r_wptr_b <= r_wptr_b + 1'b1;
      if (w_pop_a) r_rptr_a <= r_rptr_a + 1'b1;
      if (w_pop_b) r_rptr_b <= r_rptr_b + 1'b1;
      r_overflow <= r_overflow | (I_Valid_A & O_Full_A) | (I_Valid_B & O_Full_B);

      if (w_gnt_a) begin
        r_prio_b   <= 1'b1;
        r_wb_valid <= 1'b1;
        {r_wb_index, r_wb_data} <= w_fwd_a ? {I_Index_A, I_Data_A} : r_mem_a[r_rptr_a];
      end else if (w_gnt_b) begin
        r_prio_b   <= 1'b0;
        r_wb_valid <= 1'b1;
        {r_wb_index, r_wb_data} <= w_fwd_b ? {I_Index_B, I_Data_B} : r_mem_b[r_rptr_b];
      end else begin
        r_wb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (FIFO_DEPTH = 4), honours WB_ARB_FWD_EN latency.
module tb_wb_arbiter;

  localparam int unsigned INDEX_W = 6;
  localparam int unsigned DATA_W  = 32;
`ifdef WB_ARB_FWD_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic               clock = 1'b0;
  logic               reset;
  logic               I_Stall, I_Bypass_Full;
  logic               I_Valid_A, I_Valid_B;
  logic [INDEX_W-1:0] I_Index_A, I_Index_B;
  logic [DATA_W-1:0]  I_Data_A, I_Data_B;
  logic               O_Full_A, O_Full_B, O_WB_Valid, O_Overflow;
  logic [INDEX_W-1:0] O_WB_Index;
  logic [DATA_W-1:0]  O_WB_Data;

  int n_cmp = 0;
  int n_err = 0;

  wb_arbiter #(.FIFO_DEPTH(4), .INDEX_W(INDEX_W), .DATA_W(DATA_W)) u_dut (
    .clock         (clock),
    .reset         (reset),
    .I_Stall       (I_Stall),
    .I_Bypass_Full (I_Bypass_Full),
    .I_Valid_A     (I_Valid_A),
    .I_Index_A     (I_Index_A),
    .I_Data_A      (I_Data_A),
    .I_Valid_B     (I_Valid_B),
    .I_Index_B     (I_Index_B),
    .I_Data_B      (I_Data_B),
    .O_Full_A      (O_Full_A),
    .O_Full_B      (O_Full_B),
    .O_WB_Valid    (O_WB_Valid),
    .O_WB_Index    (O_WB_Index),
    .O_WB_Data     (O_WB_Data),
    .O_Overflow    (O_Overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    I_Valid_A = 1'b0; I_Index_A = '0; I_Data_A = '0;
    I_Valid_B = 1'b0; I_Index_B = '0; I_Data_B = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    I_Stall = 1'b0; I_Bypass_Full = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic expect_wb(input string tag, input int idx, input int dat);
    check({tag, ".valid"}, 32'(O_WB_Valid), 32'd1);
    check({tag, ".index"}, 32'(O_WB_Index), 32'(idx));
    check({tag, ".data"},  O_WB_Data, 32'(dat));
  endtask

  int exp_idx [8] = '{0, 10, 1, 11, 2, 12, 3, 13};
  int exp_dat [8] = '{32'h100, 32'h200, 32'h101, 32'h201, 32'h102, 32'h202, 32'h103, 32'h203};

  initial begin
    // Reset state
    do_reset();
    check("rst.valid", 32'(O_WB_Valid), 32'd0);
    check("rst.index", 32'(O_WB_Index), 32'd0);
    check("rst.data",  O_WB_Data, 32'd0);
    check("rst.full_a", 32'(O_Full_A), 32'd0);
    check("rst.full_b", 32'(O_Full_B), 32'd0);
    check("rst.ovf",   32'(O_Overflow), 32'd0);

    // Single A push: latency LAT
    I_Valid_A = 1'b1; I_Index_A = 6'd5; I_Data_A = 32'hAA;
    tick();
    idle_inputs();
    if (LAT == 2) begin
      check("single.early", 32'(O_WB_Valid), 32'd0);
      tick();
    end
    expect_wb("single", 5, 32'hAA);
    tick();
    check("single.after", 32'(O_WB_Valid), 32'd0);

    // Both sources push every cycle: alternating A/B output, starting with A
    do_reset();
    for (int t = 0; t < 12; t++) begin
      if (t < 4) begin
        I_Valid_A = 1'b1; I_Index_A = INDEX_W'(t);      I_Data_A = 32'h100 + 32'(t);
        I_Valid_B = 1'b1; I_Index_B = INDEX_W'(10 + t); I_Data_B = 32'h200 + 32'(t);
      end else begin
        idle_inputs();
      end
      tick();
      if (t >= LAT - 1 && t < LAT - 1 + 8)
        expect_wb($sformatf("rr%0d", t), exp_idx[t-LAT+1], exp_dat[t-LAT+1]);
      else
        check($sformatf("rr%0d.idle", t), 32'(O_WB_Valid), 32'd0);
    end

    // Stall while filling A, overflow on 5th push, then drain in order
    do_reset();
    I_Stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      I_Valid_A = 1'b1; I_Index_A = INDEX_W'(20 + i); I_Data_A = 32'h300 + 32'(i);
      tick();
      check($sformatf("stall%0d.valid", i), 32'(O_WB_Valid), 32'd0);
    end
    check("stall.full_a", 32'(O_Full_A), 32'd1);
    check("stall.ovf0", 32'(O_Overflow), 32'd0);
    I_Index_A = 6'd25; I_Data_A = 32'hDEAD;
    tick();
    idle_inputs();
    check("stall.ovf1", 32'(O_Overflow), 32'd1);
    check("stall.full_a2", 32'(O_Full_A), 32'd1);
    I_Stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_wb($sformatf("drain%0d", i), 20 + i, 32'h300 + i);
    end
    check("drain.full_a", 32'(O_Full_A), 32'd0);
    tick();
    check("drain.end", 32'(O_WB_Valid), 32'd0);
    check("drain.ovf_sticky", 32'(O_Overflow), 32'd1);

    // Bypass-full bubble in the middle of a 3-entry drain
    do_reset();
    I_Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      I_Valid_A = 1'b1; I_Index_A = INDEX_W'(30 + i); I_Data_A = 32'h400 + 32'(i);
      tick();
    end
    idle_inputs();
    I_Stall = 1'b0;
    tick();
    expect_wb("bf0", 30, 32'h400);
    I_Bypass_Full = 1'b1;
    tick();
    check("bf.bubble", 32'(O_WB_Valid), 32'd0);
    check("bf.hold_idx", 32'(O_WB_Index), 32'd30);
    I_Bypass_Full = 1'b0;
    tick();
    expect_wb("bf1", 31, 32'h401);
    tick();
    expect_wb("bf2", 32, 32'h402);
    tick();
    check("bf.end", 32'(O_WB_Valid), 32'd0);

    // Full FIFO with simultaneous pop and push: push dropped
    do_reset();
    I_Stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      I_Valid_A = 1'b1; I_Index_A = INDEX_W'(40 + i); I_Data_A = 32'h500 + 32'(i);
      tick();
    end
    check("pp.full", 32'(O_Full_A), 32'd1);
    I_Stall = 1'b0;
    I_Index_A = 6'd44; I_Data_A = 32'h504;
    tick();
    idle_inputs();
    expect_wb("pp0", 40, 32'h500);
    check("pp.ovf", 32'(O_Overflow), 32'd1);
    check("pp.not_full", 32'(O_Full_A), 32'd0);
    for (int i = 1; i < 4; i++) begin
      tick();
      expect_wb($sformatf("pp%0d", i), 40 + i, 32'h500 + i);
    end
    tick();
    check("pp.dropped", 32'(O_WB_Valid), 32'd0);

    // Reset with entries queued in both FIFOs discards them
    do_reset();
    I_Stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      I_Valid_A = 1'b1; I_Index_A = INDEX_W'(50 + i); I_Data_A = 32'h600 + 32'(i);
      I_Valid_B = 1'b1; I_Index_B = INDEX_W'(60 + i); I_Data_B = 32'h700 + 32'(i);
      tick();
    end
    idle_inputs();
    I_Stall = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst.valid", 32'(O_WB_Valid), 32'd0);
    check("mrst.full_a", 32'(O_Full_A), 32'd0);
    check("mrst.full_b", 32'(O_Full_B), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("mrst%0d.none", i), 32'(O_WB_Valid), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Write-back arbiter directly upstream of the bypass buffer and register-file write port.
- Collects results from two execution pipes (A: ALU path, B: MAC/long-latency path) into per-source FIFOs.
- Issues at most one write-back (index, data) per cycle.
- Output feeds the bypass buffer's write-back valid/index/data inputs.
- The bypass buffer's full flag is a back-pressure input.

Parameters:
FIFO_DEPTH, 4, entries per source FIFO; power of two, at least 2.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
I_Stall  input  1  force stall; no pop, no issue
I_Bypass_Full  input  1  downstream bypass buffer full; treated as stall for issue
I_Valid_A  input  1  source A result valid (push)
I_Index_A  input  index_t  source A write-back index
I_Data_A  input  data_t  source A write-back data
I_Valid_B  input  1  source B result valid (push)
I_Index_B  input  index_t  source B write-back index
I_Data_B  input  data_t  source B write-back data
O_Full_A  output  1  FIFO A full; upstream must not push
O_Full_B  output  1  FIFO B full; upstream must not push
O_WB_Valid  output  1  write-back valid, registered
O_WB_Index  output  index_t  write-back index, registered
O_WB_Data  output  data_t  write-back data, registered
O_Overflow  output  1  sticky: a push arrived while its FIFO was full

Behaviour:
- Reset: all outputs 0; FIFO pointers and counts 0; round-robin pointer favours A; O_Overflow cleared.
- Reset asserted mid-operation discards all queued entries. The next cycle, O_WB_Valid is 0.
- Each FIFO has a write pointer, a read pointer and a count. Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.
- O_Full_x is high when count_x equals FIFO_DEPTH. It is combinational from the registered count only.
- Push:
  - I_Valid_x with count_x < FIFO_DEPTH writes the entry at the next edge.
  - Push while full is dropped, even if a pop occurs in the same cycle, and sets O_Overflow.
  - Push is accepted regardless of I_Stall.
- Issue enable: En = ~I_Stall & ~I_Bypass_Full.
- Grant:
  - When En is high and exactly one FIFO is non-empty, that FIFO is granted.
  - When both are non-empty, the source not granted last is granted. At reset, A has priority.
  - The round-robin pointer updates only on a grant.
- Pop: the granted FIFO's head is registered into O_WB_Index/O_WB_Data. O_WB_Valid is set to 1 and the read pointer advances.
- No grant (En low or both FIFOs empty): O_WB_Valid is 0 next cycle. O_WB_Index/O_WB_Data hold their previous values.
- O_WB_Valid is high for exactly one cycle per popped entry. No entry is issued twice.
- Latency: I_Valid_x in cycle n, FIFO empty, no contention, En high -> O_WB_Valid high in cycle n+2.
- Simultaneous push and pop on the same FIFO: count unchanged. A push into a FIFO with count 0 is not poppable in the same cycle.
- Ordering: within a source, order is FIFO order. Across sources, order is round-robin only; no index-hazard ordering is enforced.
- Stall held for many cycles: entries are retained, and pushes continue until full.

Optional Feature:
WB_ARB_FWD_EN
- Defined: empty-FIFO forwarding. When a FIFO is empty, it is granted in the same cycle and En is high, the incoming I_Index_x/I_Data_x is forwarded straight to the output register without being written to the FIFO. Latency becomes n+1.
- Forwarding counts as a grant for round-robin purposes.
- A non-empty FIFO always pops its head; incoming data is queued, never forwarded past older entries.
- Undefined: latency is always n+2 as above.

Test Plan:
- Reset, then single A push (index 5, data 0xAA) with I_Stall=0 -> O_WB_Valid=1 in cycle n+2 with index 5, data 0xAA; n+1 when WB_ARB_FWD_EN is defined.
- Both sources push every cycle with A indices 0..3 and B indices 10..13 -> output alternates A0,B10,A1,B11,... starting with A; one write-back per cycle.
- I_Stall=1 while pushing FIFO_DEPTH entries to A -> O_Full_A=1 after 4 pushes, O_WB_Valid stays 0. A 5th push sets O_Overflow=1. After releasing stall, exactly 4 write-backs appear in order.
- I_Bypass_Full pulsed high for 1 cycle during a drain of 3 entries -> a single O_WB_Valid=0 bubble; all 3 entries issue once in order.
- Full FIFO A with simultaneous pop and push in the same cycle -> push dropped, O_Overflow=1, count drops to FIFO_DEPTH-1.
- Reset asserted with 2 entries queued in each FIFO -> O_WB_Valid=0 next cycle, O_Full_A/B=0, and no queued entries issue afterwards.
